// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory / MMIO responder: MMIO addresses,
// register reset values, FSM state encoding and the MMIO address decoder.
package data_mem_responder_pkg;

  localparam logic [9:0]  ADDRLEDR = 10'h3FC;
  localparam logic [9:0]  ADDRLEDG = 10'h3FD;
  localparam logic [9:0]  ADDRHEX  = 10'h3FE;

  localparam logic [9:0]  LEDR_RST = 10'h3FF;
  localparam logic [7:0]  LEDG_RST = 8'hFF;
  localparam logic [15:0] HEX_RST  = 16'hBFFF;

  typedef enum logic [1:0] {
    MEMR_IDLE = 2'd0,
    MEMR_WAIT = 2'd1,
    MEMR_RESP = 2'd2
  } memr_state_e;

  typedef enum logic [1:0] {
    MMIO_NONE = 2'd0,
    MMIO_LEDR = 2'd1,
    MMIO_LEDG = 2'd2,
    MMIO_HEX  = 2'd3
  } mmio_sel_e;

  function automatic mmio_sel_e mmio_decode(input logic [9:0] addr);
    mmio_sel_e sel;
    case (addr)
      ADDRLEDR: sel = MMIO_LEDR;
      ADDRLEDG: sel = MMIO_LEDG;
      ADDRHEX:  sel = MMIO_HEX;
      default:  sel = MMIO_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/data_mem_responder_mmio_regs.sv
// LEDR/LEDG/HEX output registers with write decode and a zero-extending read mux.
module data_mem_responder_mmio_regs
  import data_mem_responder_pkg::*;
(
  input  logic        I_CLOCK,
  input  logic        I_RESET,
  input  logic        I_WrEn,
  input  mmio_sel_e   I_Sel,
  input  logic [15:0] I_WData,
  output logic [15:0] O_RData,
  output logic [9:0]  O_LEDR,
  output logic [7:0]  O_LEDG,
  output logic [15:0] O_HexOut
);

  logic [9:0]  ledr_q;
  logic [7:0]  ledg_q;
  logic [15:0] hex_q;

  always_ff @(posedge I_CLOCK or posedge I_RESET) begin
    if (I_RESET) begin
      ledr_q <= LEDR_RST;
      ledg_q <= LEDG_RST;
      hex_q  <= HEX_RST;
    end else if (I_WrEn) begin
      case (I_Sel)
        MMIO_LEDR: ledr_q <= I_WData[9:0];
        MMIO_LEDG: ledg_q <= I_WData[7:0];
        MMIO_HEX:  hex_q  <= I_WData;
        default:   ;
      endcase
    end
  end

  always_comb begin
    O_RData = '0;
    case (I_Sel)
      MMIO_LEDR: O_RData = {6'b0, ledr_q};
      MMIO_LEDG: O_RData = {8'b0, ledg_q};
      MMIO_HEX:  O_RData = hex_q;
      default:   O_RData = '0;
    endcase
  end

  assign O_LEDR   = ledr_q;
  assign O_LEDG   = ledg_q;
  assign O_HexOut = hex_q;

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory / MMIO responder with fixed access latency.
// Define MEM_BACK2BACK_EN to accept a new request on the response handshake edge.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic              I_CLOCK,
  input  logic              I_RESET,
  input  logic              I_ReqValid,
  output logic              O_ReqReady,
  input  logic              I_ReqWrite,
  input  logic [ADDR_W-1:0] I_ReqAddr,
  input  logic [DATA_W-1:0] I_ReqWData,
  output logic              O_RespValid,
  input  logic              I_RespReady,
  output logic [DATA_W-1:0] O_RespRData,
  output logic              O_RespWrite,
  output logic              O_RespErr,
  output logic [9:0]        O_LEDR,
  output logic [7:0]        O_LEDG,
  output logic [15:0]       O_HexOut,
  output logic [1:0]        O_DbgState
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam bit LAT1  = (LATENCY == 1);

  // Handshakes: a transfer happens on a posedge where valid and ready are both 1;
  // the requester holds its request until accepted, the response is held until taken.
  memr_state_e       state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rwrite_q, rwrite_d;
  logic              err_q, err_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept, do_access;
  logic              acc_write, acc_misaligned;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata, mem_rd;
  logic [IDX_W-1:0]  acc_idx;
  mmio_sel_e         acc_sel;
  logic [15:0]       mmio_rdata;
  logic              mmio_we, mem_we;

`ifdef MEM_BACK2BACK_EN
  assign O_ReqReady = (state_q == MEMR_IDLE) || ((state_q == MEMR_RESP) && I_RespReady);
`else
  assign O_ReqReady = (state_q == MEMR_IDLE);
`endif

  assign accept = O_ReqReady && I_ReqValid;

  // With LATENCY=1 the access happens on the accept edge, so it uses the live request.
  assign acc_write      = LAT1 ? I_ReqWrite : wr_q;
  assign acc_addr       = LAT1 ? I_ReqAddr  : addr_q;
  assign acc_wdata      = LAT1 ? I_ReqWData : wdata_q;
  assign do_access      = LAT1 ? accept : ((state_q == MEMR_WAIT) && (cnt_q == 4'd1));
  assign acc_idx        = acc_addr[IDX_W:1];
  assign acc_sel        = mmio_decode(acc_addr[9:0]);
  assign acc_misaligned = acc_addr[0] && (acc_sel == MMIO_NONE);
  assign mem_rd         = mem[acc_idx];
  assign mmio_we        = do_access && acc_write && (acc_sel != MMIO_NONE);
  assign mem_we         = do_access && acc_write && (acc_sel == MMIO_NONE) && !acc_misaligned;

  wire unused_addr_bits = ^acc_addr[ADDR_W-1:IDX_W+1];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    rwrite_d = rwrite_q;
    err_d    = err_q;

    case (state_q)
      MEMR_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = MEMR_RESP;
      end
      MEMR_RESP: begin
        if (I_RespReady) begin
          state_d = MEMR_IDLE;
          err_d   = 1'b0;
        end
      end
      default: ;
    endcase

    if (accept) begin
      wr_d    = I_ReqWrite;
      addr_d  = I_ReqAddr;
      wdata_d = I_ReqWData;
      cnt_d   = 4'(LATENCY - 1);
      state_d = LAT1 ? MEMR_RESP : MEMR_WAIT;
    end

    if (do_access) begin
      rwrite_d = acc_write;
      err_d    = acc_misaligned;
      if (acc_misaligned || acc_write) rdata_d = '0;
      else if (acc_sel != MMIO_NONE)   rdata_d = DATA_W'(mmio_rdata);
      else                             rdata_d = mem_rd;
    end
  end

  always_ff @(posedge I_CLOCK or posedge I_RESET) begin
    if (I_RESET) begin
      state_q  <= MEMR_IDLE;
      cnt_q    <= '0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      rwrite_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      rwrite_q <= rwrite_d;
      err_q    <= err_d;
    end
  end

  // Memory contents survive reset; the reset term only blocks a write racing it.
  always_ff @(posedge I_CLOCK) begin
    if (mem_we && !I_RESET) mem[acc_idx] <= acc_wdata;
  end

  data_mem_responder_mmio_regs u_mmio (
    .I_CLOCK  (I_CLOCK),
    .I_RESET  (I_RESET),
    .I_WrEn   (mmio_we),
    .I_Sel    (acc_sel),
    .I_WData  (acc_wdata[15:0]),
    .O_RData  (mmio_rdata),
    .O_LEDR   (O_LEDR),
    .O_LEDG   (O_LEDG),
    .O_HexOut (O_HexOut)
  );

  assign O_RespValid = (state_q == MEMR_RESP);
  assign O_RespRData = rdata_q;
  assign O_RespWrite = rwrite_q;
  assign O_RespErr   = err_q;
  assign O_DbgState  = state_q;

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Multi-cycle data-memory and memory-mapped I/O responder. It is the target side of the load/store requests issued by the pipeline memory stage.
- Accepts one request at a time over a valid/ready handshake and performs the word read or write after a fixed latency.
- Owns the LEDR/LEDG/HEX output registers and returns load data or a store acknowledge over a valid/ready response channel.

Parameters:
- DATA_W, 16, data word width.
- ADDR_W, 16, byte-address width of I_ReqAddr.
- DEPTH, 1024, number of DATA_W words in data memory.
- LATENCY, 2, cycles from request accept to response valid; legal range 1..15.

Ports:
- I_CLOCK  in  1  clock; all state updates on posedge.
- I_RESET  in  1  reset, asynchronous, active-high.
- I_ReqValid  in  1  request present.
- O_ReqReady  out  1  responder can accept a request.
- I_ReqWrite  in  1  1 = store, 0 = load.
- I_ReqAddr  in  ADDR_W  byte address.
- I_ReqWData  in  DATA_W  store data.
- O_RespValid  out  1  response present.
- I_RespReady  in  1  requester takes the response.
- O_RespRData  out  DATA_W  load data; 0 for stores.
- O_RespWrite  out  1  echo of the accepted request's I_ReqWrite.
- O_RespErr  out  1  misaligned address; the access was not performed.
- O_LEDR  out  10  LEDR register.
- O_LEDG  out  8  LEDG register.
- O_HexOut  out  16  HEX register, drives the four SevenSeg digits.

Behaviour:
- Reset (async, while I_RESET=1):
  - State = IDLE.
  - O_ReqReady=1, O_RespValid=0, O_RespRData=0, O_RespWrite=0, O_RespErr=0.
  - O_LEDR=10'h3FF, O_LEDG=8'hFF, O_HexOut=16'hBFFF.
  - Data memory contents are not reset.
- Word index = I_ReqAddr >> 1, truncated to log2(DEPTH) bits, so out-of-range addresses wrap.
- MMIO decode uses I_ReqAddr[9:0]: 0x3FC = LEDR, 0x3FD = LEDG, 0x3FE = HEX.
  - MMIO decode takes priority over the alignment check and over memory.
  - An MMIO store never writes data memory.
- Misaligned: I_ReqAddr[0]=1 and the address is not MMIO.
- States: IDLE, WAIT, RESP.
- IDLE:
  - O_ReqReady=1.
  - On I_ReqValid=1: latch write/addr/wdata, load cnt=LATENCY-1.
  - If LATENCY=1, go to EXEC-then-RESP in the same edge (see access rule); otherwise go to WAIT.
- WAIT:
  - O_ReqReady=0; cnt decrements each cycle.
  - On the edge where cnt==1 (or on the accept edge when LATENCY=1), the access is performed and the state goes to RESP.
- Access rule, applied exactly once per request:
  - Store to memory: mem[idx] <= wdata.
  - Store to LEDR / LEDG / HEX: takes wdata[9:0] / wdata[7:0] / wdata[15:0].
  - Load from memory: O_RespRData <= mem[idx].
  - Load from LEDR: returns the register zero-extended; LEDG likewise; HEX returns the full 16 bits.
  - Misaligned: nothing written, O_RespRData <= 0, O_RespErr <= 1.
- RESP:
  - O_RespValid=1; O_RespRData, O_RespWrite and O_RespErr are held stable until I_RespReady=1.
  - On handshake: O_RespValid=0, O_RespErr=0, return to IDLE.
  - O_ReqReady=0 in RESP unless the optional feature is compiled in.
- Latency: O_RespValid rises exactly LATENCY posedges after the accept edge.
- Throughput: one request per LATENCY+1 cycles without the feature.
- Reset mid-operation:
  - In WAIT, the pending access is discarded and no write is committed.
  - In RESP, the response is dropped.
  - MMIO registers return to their reset values.
- I_RespReady while not in RESP is ignored. I_ReqValid while O_ReqReady=0 is ignored; the requester must hold the request.

Optional Feature:
- MEM_BACK2BACK_EN defined:
  - In RESP, O_ReqReady = I_RespReady, so a new request is accepted on the same edge as the response handshake.
  - The next response arrives LATENCY cycles later, for a throughput of one request per LATENCY cycles.
- MEM_BACK2BACK_EN undefined: RESP always returns to IDLE for one cycle before the next request can be accepted.

Decomposition:
- Shared package/header (global_def.h):
  - ADDRLEDR/ADDRLEDG/ADDRHEX constants.
  - State encodings MEMR_IDLE/MEMR_WAIT/MEMR_RESP.
  - MMIO reset values for LEDR/LEDG/HEX.
- One sub-module, mmio_regs: holds LEDR/LEDG/HEX with write-enable decode and read mux; instantiated once.
- The memory array lives in data_mem_responder.

Test Plan:
- Reset then store 0x00A4←0x1234, load 0x00A4 → store response O_RespWrite=1 two cycles after accept; load returns 0x1234, O_RespErr=0.
- Store 0x03FE←0xC0DE, then store 0x03FC←0xFFFF → O_HexOut=0xC0DE, O_LEDR=0x3FF, memory word 0x1FF unchanged; load 0x03FE returns 0xC0DE.
- Load 0x0011 (misaligned) → O_RespErr=1, O_RespRData=0, no memory change; the next aligned load has O_RespErr=0.
- Hold I_RespReady=0 for 5 cycles → O_RespValid and O_RespRData stable; O_ReqReady=0 throughout; one cycle after handshake, O_ReqReady=1 (O_ReqReady rises on the handshake edge with MEM_BACK2BACK_EN).
- Assert I_RESET in WAIT of store 0x0020←0xBEEF → after reset, load 0x0020 returns the prior value; O_HexOut=0xBFFF, O_LEDG=0xFF.
- Address 0x0802 with DEPTH=1024 → aliases word 0x001 (compare with store to 0x0002); LATENCY=1 build: response valid one cycle after accept.
